// File: rtl/pio128_pkg.sv
// Shared types and helpers for the 128-bit outbound PIO port.
// Word/byte-enable widths and the byte-merge function.
package pio128_pkg;

    localparam int PIO_W    = 128;
    localparam int PIO_BE_W = PIO_W / 8;

    typedef logic [PIO_W-1:0]    pio_word_t;
    typedef logic [PIO_BE_W-1:0] pio_be_t;

    // Bytes with be set come from new_w, the rest keep old_w.
    function automatic pio_word_t be_merge(
        input pio_word_t old_w,
        input pio_word_t new_w,
        input pio_be_t   be
    );
        pio_word_t m;
        m = old_w;
        for (int i = 0; i < PIO_BE_W; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pio128_sync_fifo.sv
// First-word-fall-through FIFO of 128-bit words.
// Push is ignored when full, pop is ignored when empty.
module pio128_sync_fifo
    import pio128_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  pio_word_t              push_data,
    input  logic                   pop,
    output pio_word_t              head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    pio_word_t         mem_q [DEPTH];
    pio_word_t         mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push;
    logic              do_pop;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers; reset drops every queued entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/pio128_out.sv
// Avalon-MM write-only slave: byte-merges writes into a shadow
// word and queues each merged word for the fabric to drain.
module pio128_out
    import pio128_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   block_write,
    input  logic                   avs_s0_write,
    input  logic [127:0]           avs_s0_writedata,
    input  logic [15:0]            avs_s0_byteenable,
    output logic                   waitrequest,
    output logic                   write_strobe,
    output logic [127:0]           pio_out,
    output logic                   pio_out_valid,
    input  logic                   pio_out_ready,
    output logic [$clog2(DEPTH):0] fifo_level
);

    pio_word_t shadow_q, shadow_d;
    pio_word_t merged;
    pio_word_t head;
    logic      strobe_q, strobe_d;
    logic      accept;
    logic      pop;
    logic      full;
    logic      empty;

    assign waitrequest   = block_write | full;
    assign pio_out_valid = ~empty;
    assign pio_out       = pio_out_valid ? head : '0;
    assign write_strobe  = strobe_q;
    assign pop           = pio_out_valid & pio_out_ready;

    // Accept decision and byte-merge into the shadow word.
    always_comb begin
        accept   = avs_s0_write & ~waitrequest;
        merged   = be_merge(shadow_q, avs_s0_writedata,
                            avs_s0_byteenable);
        shadow_d = accept ? merged : shadow_q;
        strobe_d = accept;
    end

    // Shadow word and the one-cycle write pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            strobe_q <= strobe_d;
        end
    end

    pio128_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (merged),
        .pop       (pop),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_pio128_out.sv
// Scoreboard bench for pio128_out: stimulus pushes expected words,
// a monitor compares DUT outputs every cycle against the model.
module tb_pio128_out;

    localparam int DEPTH = 4;

    logic         clk;
    logic         reset_n;
    logic         block_write;
    logic         avs_s0_write;
    logic [127:0] avs_s0_writedata;
    logic [15:0]  avs_s0_byteenable;
    logic         waitrequest;
    logic         write_strobe;
    logic [127:0] pio_out;
    logic         pio_out_valid;
    logic         pio_out_ready;
    logic [2:0]   fifo_level;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] shadow_m;
    bit           strobe_exp;
    bit           chk_en;
    bit           last_acc;

    pio128_out #(
        .DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .block_write       (block_write),
        .avs_s0_write      (avs_s0_write),
        .avs_s0_writedata  (avs_s0_writedata),
        .avs_s0_byteenable (avs_s0_byteenable),
        .waitrequest       (waitrequest),
        .write_strobe      (write_strobe),
        .pio_out           (pio_out),
        .pio_out_valid     (pio_out_valid),
        .pio_out_ready     (pio_out_ready),
        .fifo_level        (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, update model after posedge.
    task automatic cyc(input bit rst, input bit wr,
                       input logic [127:0] d, input logic [15:0] be,
                       input bit rdy, input bit blk);
        bit acc;
        @(negedge clk);
        reset_n           = ~rst;
        avs_s0_write      = wr;
        avs_s0_writedata  = d;
        avs_s0_byteenable = be;
        pio_out_ready     = rdy;
        block_write       = blk;
        acc = !rst && wr && !(blk || exp_q.size() == DEPTH);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            shadow_m   = '0;
            strobe_exp = 1'b0;
        end else begin
            strobe_exp = acc;
            if (acc) begin
                for (int i = 0; i < 16; i++)
                    if (be[i]) shadow_m[8*i +: 8] = d[8*i +: 8];
                exp_q.push_back(shadow_m);
            end
        end
        last_acc = acc;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++)
            cyc(0, 0, '0, '0, 1, 0);
        chk("drain_timeout", 128'(exp_q.size()), 0);
        chk("drain_level", fifo_level, 0);
    endtask

    // Monitor: compares outputs and pops the scoreboard on handshakes.
    always begin
        int n;
        @(negedge clk);
        #2;
        if (chk_en) begin
            n = exp_q.size();
            chk("waitrequest", waitrequest,
                block_write | (n == DEPTH));
            chk("valid", pio_out_valid, n != 0);
            chk("level", fifo_level, n);
            chk("pio_out", pio_out, (n != 0) ? exp_q[0] : '0);
            chk("write_strobe", write_strobe, strobe_exp);
            if (reset_n && n != 0 && pio_out_ready)
                void'(exp_q.pop_front());
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] w;
        logic [15:0]  be;
        reset_n = 0; block_write = 0; avs_s0_write = 0;
        avs_s0_writedata = '0; avs_s0_byteenable = '0;
        pio_out_ready = 0; shadow_m = '0; strobe_exp = 0;
        chk_en = 0; last_acc = 0;

        // reset held 3 cycles with write asserted
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, rnd128(), 16'hFFFF, 0, 0);
            chk_en = 1;
        end
        chk("rst_wait", waitrequest, 0);
        chk("rst_valid", pio_out_valid, 0);
        chk("rst_pio", pio_out, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_strobe", write_strobe, 0);

        // single write
        w = 128'h0123456789ABCDEF0123456789ABCDEF;
        cyc(0, 1, w, 16'hFFFF, 0, 0);
        chk("sw_valid", pio_out_valid, 1);
        chk("sw_pio", pio_out, w);
        chk("sw_level", fifo_level, 1);
        chk("sw_strobe", write_strobe, 1);
        cyc(0, 0, '0, '0, 0, 0);
        chk("sw_strobe_off", write_strobe, 0);
        drain();

        // byte merge
        cyc(0, 1, {16{8'hAA}}, 16'hFFFF, 0, 0);
        drain();
        cyc(0, 1, {16{8'h55}}, 16'h000F, 0, 0);
        chk("merge", pio_out, {{12{8'hAA}}, {4{8'h55}}});
        drain();

        // fill and back-pressure
        for (int i = 1; i <= 4; i++)
            cyc(0, 1, {4{32'(i)}}, 16'hFFFF, 0, 0);
        chk("fill_level", fifo_level, 4);
        chk("fill_wait", waitrequest, 1);
        cyc(0, 1, {4{32'd5}}, 16'hFFFF, 0, 0);
        chk("stall_level", fifo_level, 4);
        chk("stall_acc", last_acc, 0);
        cyc(0, 1, {4{32'd5}}, 16'hFFFF, 1, 0);
        chk("freed_level", fifo_level, 3);
        chk("freed_wait", waitrequest, 0);
        cyc(0, 1, {4{32'd5}}, 16'hFFFF, 0, 0);
        chk("fifth_level", fifo_level, 4);
        chk("fifth_strobe", write_strobe, 1);
        drain();

        // simultaneous push and pop at level 2
        cyc(0, 1, rnd128(), 16'hFFFF, 0, 0);
        cyc(0, 1, rnd128(), 16'hFFFF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, rnd128(), 16'($urandom), 1, 0);
            chk("pp_level", fifo_level, 2);
        end
        drain();

        // block_write on empty fifo
        cyc(0, 1, rnd128(), 16'hFFFF, 0, 1);
        chk("blk_wait", waitrequest, 1);
        chk("blk_level", fifo_level, 0);
        chk("blk_valid", pio_out_valid, 0);

        // mid-stream reset
        for (int i = 0; i < 3; i++)
            cyc(0, 1, rnd128(), 16'hFFFF, 0, 0);
        chk("mid_level3", fifo_level, 3);
        cyc(1, 0, '0, '0, 0, 0);
        chk("mid_level0", fifo_level, 0);
        chk("mid_valid", pio_out_valid, 0);
        cyc(0, 1, 128'hFF, 16'h0001, 0, 0);
        chk("mid_shadow", pio_out, 128'hFF);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       be = 16'h0000;
                1:       be = 16'hFFFF;
                default: be = 16'($urandom);
            endcase
            cyc($urandom_range(0, 149) == 0,
                $urandom_range(0, 2) != 0, rnd128(), be,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 4) == 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
